// File: rtl/dilated_tap_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dilated_tap_cache_pkg                                      |
// | Brief    : Geometry helpers shared by the dilated tap cache family.   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dilated_tap_cache_pkg;

  // History entries needed so that the oldest tap is still resident.
  function automatic int unsigned num_entries(input int unsigned kernel,
                                              input int unsigned dilation);
    return (kernel - 1) * dilation;
  endfunction

  // Pointer width; a single-entry history still needs one bit.
  function automatic int unsigned addr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Wrapped read address of tap k. The +entries term keeps the
  // subtraction non-negative, so plain unsigned modulo is safe.
  function automatic int unsigned tap_addr(input int unsigned head,
                                           input int unsigned k,
                                           input int unsigned kernel,
                                           input int unsigned dilation,
                                           input int unsigned entries);
    return (head + entries - (kernel - 1 - k) * dilation) % entries;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dilated_tap_cache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dilated_tap_cache_if                                       |
// | Brief    : Sample-in / taps-out bus of the dilated tap cache.         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface dilated_tap_cache_if
  import dilated_tap_cache_pkg::*;
#(
  parameter int W = 16,
  parameter int C = 4,
  parameter int K = 4
);
  logic               inp_valid;
  logic [C*W-1:0]     inp;
  logic               out_valid;
  logic [K*C*W-1:0]   out;

  modport master (output inp_valid, inp, input out_valid, out);
  modport slave  (input inp_valid, inp, output out_valid, out);
endinterface
`default_nettype wire

// File: rtl/dilated_tap_cache_tap_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tap_addr_gen                                               |
// | Brief    : Combinational wrapped read addresses for the K-1 history   |
// |            taps, given the current write head.                        |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tap_addr_gen
  import dilated_tap_cache_pkg::*;
#(
  parameter int K           = 4,
  parameter int DILATION    = 4,
  parameter int NUM_ENTRIES = 12,
  parameter int ADDR_W      = 4
) (
  input  logic [ADDR_W-1:0]       head,
  output logic [(K-1)*ADDR_W-1:0] addr
);
  // One wrapped address per stored tap; tap K-1 comes straight from the input.
  for (genvar k = 0; k < K - 1; k++) begin : g_tap
    assign addr[k*ADDR_W +: ADDR_W] =
      ADDR_W'(tap_addr(32'(head), k, K, DILATION, NUM_ENTRIES));
  end
endmodule
`default_nettype wire

// File: rtl/dilated_tap_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dilated_tap_cache                                          |
// | Brief    : Multi-channel history buffer presenting all K dilated      |
// |            taps of every channel in parallel, one cycle latency.      |
// |            Option macro DILATED_TAP_CACHE_WARMUP_GATE_EN suppresses   |
// |            out_valid until the history is completely filled.          |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dilated_tap_cache
  import dilated_tap_cache_pkg::*;
#(
  parameter int W        = 16,
  parameter int C        = 4,
  parameter int K        = 4,
  parameter int DILATION = 4
) (
  input  logic clk,
  input  logic rst,
  dilated_tap_cache_if.slave bus
);
  localparam int NUM_ENTRIES = int'(num_entries(K, DILATION));
  localparam int ADDR_W      = int'(addr_width(NUM_ENTRIES));
  localparam int CW          = C * W;

  logic [CW-1:0]           buffer [NUM_ENTRIES];
  logic [ADDR_W-1:0]       write_head;
  logic [(K-1)*ADDR_W-1:0] rd_addr;
  logic [K*CW-1:0]         taps;
  logic                    taps_valid;
  logic                    history_full;

  tap_addr_gen #(
    .K           (K),
    .DILATION    (DILATION),
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (ADDR_W)
  ) u_tap_addr_gen (
    .head (write_head),
    .addr (rd_addr)
  );

`ifdef DILATED_TAP_CACHE_WARMUP_GATE_EN
  localparam int FILL_W = $clog2(NUM_ENTRIES + 1);
  logic [FILL_W-1:0] fill_count;

  // Saturating count of accepted samples since reset.
  always_ff @(posedge clk) begin
    if (rst)
      fill_count <= '0;
    else if (bus.inp_valid && fill_count != FILL_W'(NUM_ENTRIES))
      fill_count <= fill_count + 1'b1;
  end

  assign history_full = (fill_count == FILL_W'(NUM_ENTRIES));
`else
  assign history_full = 1'b1;
`endif

  // Write pointer advances once per accepted sample, wrapping at any depth.
  always_ff @(posedge clk) begin
    if (rst)
      write_head <= '0;
    else if (bus.inp_valid)
      write_head <= (write_head == ADDR_W'(NUM_ENTRIES - 1)) ? '0 : write_head + 1'b1;
  end

  // History storage; cleared on reset to give causal zero padding.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        buffer[i] <= '0;
    end else if (bus.inp_valid) begin
      buffer[write_head] <= bus.inp;
    end
  end

  // Tap register: reads use pre-edge contents, holds across input gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      taps       <= '0;
      taps_valid <= 1'b0;
    end else begin
      taps_valid <= bus.inp_valid && history_full;
      if (bus.inp_valid) begin
        for (int k = 0; k < K - 1; k++)
          taps[k*CW +: CW] <= buffer[rd_addr[k*ADDR_W +: ADDR_W]];
        taps[(K-1)*CW +: CW] <= bus.inp;
      end
    end
  end

  assign bus.out       = taps;
  assign bus.out_valid = taps_valid;
endmodule
`default_nettype wire
